// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int          IMEM_DEPTH_DEF = 64;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] NOP            = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: squash wins over stall, stall holds, otherwise load.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        squash_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus1_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus1_o,
    output logic        valid_o
);
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus1_q, pc_plus1_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        if (squash_i) begin
            // PC+1 is left alone on a squash; it is meaningless while valid is low
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d    = instr_i;
            pc_plus1_d = pc_plus1_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q    <= NOP;
            pc_plus1_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/instruction_fetch.sv
// Word-addressed fetch stage: PC register, RUN/FAULT FSM and IF/ID register.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PCPlus1,
    output logic        IF_Valid,
    output logic        FetchFault
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q;
    logic [31:0]  pc_plus1;
    logic         squash;
    logic         fetch_live;
    logic         oob;
    logic         fault_hit;

    assign pc_plus1   = pc_q + 32'd1;
    assign squash     = Flush | BranchTaken;
    assign fetch_live = !Stall && !squash;
    assign oob        = (pc_q >= 32'(IMEM_DEPTH));

`ifdef FETCH_BOUNDS_CHECK_EN
    assign fault_hit = (state_q == RUN) && fetch_live && oob;
`else
    logic unused_oob;
    assign unused_oob = oob;
    assign fault_hit  = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (state_q == FAULT || fault_hit) pc_d = pc_q;
        else if (BranchTaken)              pc_d = BranchTarget;
        else if (!Stall)                   pc_d = pc_plus1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            fault_q <= 1'b0;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                RUN: if (fault_hit) begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
                FAULT: ; // only reset leaves FAULT
                default: state_q <= RUN;
            endcase
        end
    end

    // Faulting fetch and everything after it are kept out of the pipe
    ifid_reg u_ifid (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .stall_i    (Stall),
        .squash_i   (squash || fault_hit || state_q == FAULT),
        .instr_i    (Instruction),
        .pc_plus1_i (pc_plus1),
        .instr_o    (IF_Instr),
        .pc_plus1_o (IF_PCPlus1),
        .valid_o    (IF_Valid)
    );

    assign ReadAddress = pc_q;
    assign FetchFault  = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a reference model feeding a scoreboard queue.
module tb_instruction_fetch;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Stall = 1'b0, Flush = 1'b0, BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] ReadAddress, Instruction, IF_Instr, IF_PCPlus1;
    logic        IF_Valid, FetchFault;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] imem [64];
    int          tests = 0, fails = 0;

    logic [31:0] mpc, minstr, mpcp1;
    logic        mvalid, mfault;

    instruction_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ReadAddress(ReadAddress), .Instruction(Instruction),
        .IF_Instr(IF_Instr), .IF_PCPlus1(IF_PCPlus1), .IF_Valid(IF_Valid),
        .FetchFault(FetchFault)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a < 32'd64) ? imem[a[5:0]] : 32'h0;
    endfunction

    assign Instruction = img(ReadAddress);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mpc = 32'h0; minstr = 32'h0; mpcp1 = 32'h0; mvalid = 1'b0; mfault = 1'b0;
    endtask

    // Enter with Clk low; asserts reset, checks async values, releases on a falling edge.
    task automatic do_reset();
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = 0;
        Rst_n = 1'b0;
        #1;
        chk("rst_pc",    ReadAddress, 32'h0);
        chk("rst_valid", {31'h0, IF_Valid}, 32'h0);
        chk("rst_instr", IF_Instr, 32'h0);
        chk("rst_pcp1",  IF_PCPlus1, 32'h0);
        chk("rst_fault", {31'h0, FetchFault}, 32'h0);
        model_reset();
        sb.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    // Drive one cycle of controls, push model expectation, compare after the edge.
    task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
        exp_t e;
        logic sq, fetch, fh;
        Stall = st; Flush = fl; BranchTaken = br; BranchTarget = tgt;
        sq    = fl | br;
        fetch = !st && !sq;
        if (mfault) begin
            mvalid = 1'b0; minstr = 32'h0;
        end else begin
            fh = BOUNDS && fetch && (mpc >= 32'd64);
            if (sq || fh) begin
                mvalid = 1'b0; minstr = 32'h0;
            end else if (!st) begin
                minstr = img(mpc); mpcp1 = mpc + 32'd1; mvalid = 1'b1;
            end
            if (fh)       mfault = 1'b1;
            else if (br)  mpc = tgt;
            else if (!st) mpc = mpc + 32'd1;
        end
        sb.push_back('{pc: mpc, instr: minstr, pcp1: mpcp1, valid: mvalid, fault: mfault});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("sb_pc",    ReadAddress, e.pc);
        chk("sb_instr", IF_Instr, e.instr);
        chk("sb_valid", {31'h0, IF_Valid}, {31'h0, e.valid});
        chk("sb_fault", {31'h0, FetchFault}, {31'h0, e.fault});
        if (e.valid) chk("sb_pcp1", IF_PCPlus1, e.pcp1);
        @(negedge Clk);
        Stall = 0; Flush = 0; BranchTaken = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 5; i++)  imem[i] = 32'h012A4020;
        imem[5] = 32'h012A4022;
        imem[6] = 32'h02328022;
        imem[7] = 32'h02328022;

        // sequential fetch after reset
        do_reset();
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        chk("seq_last_instr", IF_Instr, 32'h02328022);
        chk("seq_last_pcp1",  IF_PCPlus1, 32'd7);

        // stall at PC=5 for three cycles
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("stall_pc",    ReadAddress, 32'd5);
        chk("stall_instr", IF_Instr, 32'h012A4020);
        step(0, 0, 0, 0);
        chk("stall_rel_instr", IF_Instr, 32'h012A4022);
        chk("stall_rel_pcp1",  IF_PCPlus1, 32'd6);

        // branch from PC=2 to 6
        do_reset();
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 32'd6);
        chk("br_valid", {31'h0, IF_Valid}, 32'h0);
        chk("br_pc",    ReadAddress, 32'd6);
        step(0, 0, 0, 0);
        chk("br_instr", IF_Instr, 32'h02328022);
        chk("br_pcp1",  IF_PCPlus1, 32'd7);

        // branch wins over stall
        step(1, 0, 1, 32'd2);
        chk("brst_pc", ReadAddress, 32'd2);

        // flush + stall at PC=3
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("flst_valid", {31'h0, IF_Valid}, 32'h0);
        chk("flst_pc",    ReadAddress, 32'd3);
        step(0, 0, 0, 0);
        chk("flst_instr", IF_Instr, 32'h012A4020);
        chk("flst_pcp1",  IF_PCPlus1, 32'd4);

        // branch just past the end of instruction memory
        do_reset();
        step(0, 0, 1, 32'd64);
        step(0, 0, 0, 0);
        if (BOUNDS) begin
            chk("oob_fault", {31'h0, FetchFault}, 32'h1);
            chk("oob_pc",    ReadAddress, 32'd64);
            step(0, 0, 1, 32'd3);
            chk("oob_frozen", ReadAddress, 32'd64);
        end else begin
            chk("oob_nofault", {31'h0, FetchFault}, 32'h0);
            chk("oob_pc",      ReadAddress, 32'd65);
            step(0, 0, 0, 0);
            chk("oob_pc2",   ReadAddress, 32'd66);
            chk("oob_valid", {31'h0, IF_Valid}, 32'h1);
        end
        #2;
        do_reset();

        // 32-bit PC wrap
        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
